sd_cmd_sender: RTL and testbench
================================

# sd_cmd_sender

Command-path sequencer for the SD CMD line, placed directly upstream of the CMD response parser.
- Serialises one 48-bit host command with generated CRC7, one bit per CLK tic.
- Releases the line for turnaround, then arms the parser through `O_RX_EN`, `O_RX_48` and `O_RX_136`.
- Waits for the parser's completion tic or its timeout, enforces the Ncc gap, and reports a status to the host-side controller.

## Interface
Parameters:
- `TURN_CYCLES`, default 2: tics with `O_CMD_OE`=0 between end bit and response arming (Ncr).
- `GAP_CYCLES`, default 8: idle tics after the response or timeout before the next command (Ncc).

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  SD bit clock; one tic = one CMD bit.
- `RST`  in  1  synchronous, active-high reset.
- `I_STB`  in  1  command request; accepted only when `O_READY`=1.
- `I_IDX`  in  6  command index.
- `I_ARG`  in  32  command argument.
- `I_RESP`  in  2  response type: 00 none, 01 48-bit, 10 136-bit, 11 treated as none.
- `O_READY`  out  1  idle, can accept `I_STB`.
- `O_CMD_OUT`  out  1  CMD line drive value.
- `O_CMD_OE`  out  1  CMD line output enable.
- `O_RX_EN`  out  1  parser enable (drives parser `I_EN`).
- `O_RX_48`, `O_RX_136`  out  1 each  parser response-length select.
- `I_RX_TIC`  in  1  parser command-complete tic.
- `I_RX_CRC_OK`  in  1  parser CRC-valid flag; sampled with `I_RX_TIC`.
- `I_RX_TIMEOUT`  in  1  parser timeout flag.
- `O_DONE`  out  1  one-tic completion pulse.
- `O_ST_OK`, `O_ST_CRCERR`, `O_ST_TIMEOUT`  out  1 each  status; valid from `O_DONE` until the next accept.

## Operation
- States: IDLE → SEND → TURN → WAIT → GAP → IDLE.
- IDLE:
  - `O_READY`=1.
  - On `I_STB`, latch `{0,1,I_IDX,I_ARG}` plus `I_RESP` and clear all status flags.
  - Go to SEND.
- SEND:
  - 48 tics, MSB first: start 0, transmit 1, index, argument, CRC7, end 1.
  - CRC7 (x^7+x^3+1) is computed over the first 40 bits as they shift out. The 7-bit result is loaded into the shifter in time for frame bit 40.
- TURN:
  - `TURN_CYCLES` tics with `O_CMD_OE`=0 and `O_CMD_OUT`=1.
  - Then go to WAIT, or to GAP if `I_RESP` is none or 11; in that case `O_ST_OK` is set.
- WAIT:
  - `O_RX_EN`=1; `O_RX_48` or `O_RX_136` held per `I_RESP`.
  - On `I_RX_TIC`: `O_ST_OK`=`I_RX_CRC_OK` and `O_ST_CRCERR`=!`I_RX_CRC_OK`.
  - Else on `I_RX_TIMEOUT`: `O_ST_TIMEOUT`=1.
  - Either event leads to GAP, and `O_RX_EN` drops on the next tic.
  - If both arrive in the same tic, `I_RX_TIC` wins.
- GAP:
  - `GAP_CYCLES` tics with OE=0 and `O_RX_EN`=0.
  - Then return to IDLE with a single `O_DONE` pulse.
- `I_STB` outside IDLE is ignored and not queued.
- Reset values: `O_READY`=1, `O_CMD_OUT`=1, `O_CMD_OE`=0, `O_RX_*`=0, `O_DONE`=0, all status flags 0.
- Reset mid-operation: the next tic is IDLE, the line is released, and no `O_DONE` is issued.

## Timing
- Accept edge = tic 0. Frame bit k (k=0..47) is on `O_CMD_OUT` with OE=1 during tic 1+k.
- TURN covers tics 49..48+`TURN_CYCLES`.
- WAIT starts at tic 49+`TURN_CYCLES`, i.e. tic 51 at default.
- WAIT exit: the event seen in tic t puts GAP in tics t+1..t+`GAP_CYCLES`. `O_DONE`, `O_READY`=1 and status are all valid in tic t+`GAP_CYCLES`+1.
- No-response command: `O_DONE` in tic 49+`TURN_CYCLES`+`GAP_CYCLES`, i.e. tic 59 at default.
- Back-to-back: `I_STB` held high with `O_DONE` is accepted in that same tic.
- Counters:
  - 6-bit bit counter for SEND.
  - 4-bit counter shared by TURN and GAP; `TURN_CYCLES` and `GAP_CYCLES` range 1..15.
  - No wrap-around: every counter reloads on state entry.

## Structure
- Shared SD package holds:
  - response-type encodings (`RESP_NONE`, `RESP_48`, `RESP_136`);
  - frame constants (`CMD_FRAME_BITS`=48, `CMD_CRC_BITS`=40);
  - state encoding.
- One sub-module: the existing `sd_crc7`.
  - `EN` high during frame bits 0..39.
  - `RST` driven by RST or the IDLE state.
  - `SH`=0.

## Test plan
- CMD0, arg 0, `I_RESP`=00: serial frame equals 0x400000000095 (CRC 0x4A); `O_DONE` at tic 59 with `O_ST_OK`=1; `O_RX_EN` never asserted.
- CMD8, arg 0x1AA, `I_RESP`=01: frame equals 0x48000001AA87; `O_RX_EN` and `O_RX_48`=1 from tic 51. Parser tic with CRC ok at tic 70 → `O_DONE` at tic 79 with `O_ST_OK`=1.
- CMD2, `I_RESP`=10, `I_RX_CRC_OK`=0 → `O_RX_136`=1 during WAIT; `O_ST_CRCERR`=1 at `O_DONE`.
- WAIT with `I_RX_TIMEOUT` only → `O_ST_TIMEOUT`=1, `O_ST_OK`=0. Also `I_RX_TIC` and `I_RX_TIMEOUT` in the same tic → `O_ST_OK`=1.
- `I_STB` pulsed during SEND → ignored, frame unchanged. `I_STB` held at `O_DONE` → second frame's start bit at the tic after `O_DONE`.
- `RST` at frame bit 20 → next tic `O_CMD_OE`=0, `O_CMD_OUT`=1, `O_READY`=1, no `O_DONE`. A following CMD0 is produced correctly.

Source files
------------

// File: rtl/sd_cmd_sender_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_cmd_sender_pkg: shared SD command-path types, constants and CRC7   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sd_cmd_sender_pkg;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_48   = 2'b01;
  localparam logic [1:0] RESP_136  = 2'b10;

  localparam int CMD_FRAME_BITS = 48;
  localparam int CMD_CRC_BITS   = 40;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_TURN = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4
  } sd_state_e;

  // One serial step of CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic dat);
    logic w_fb;
    w_fb = dat ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, w_fb, 2'b00, w_fb};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_crc7: bit-serial CRC7 accumulator with optional shift-out          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sd_crc7
  import sd_cmd_sender_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       SH,
  input  logic       I_DAT,
  output logic [6:0] O_CRC
);

  logic [6:0] r_crc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_crc <= 7'd0;
    end else if (EN) begin
      r_crc <= crc7_step(r_crc, I_DAT);
    end else if (SH) begin
      r_crc <= {r_crc[5:0], 1'b0};
    end
  end

  assign O_CRC = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_sender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_cmd_sender: serialises one SD command with CRC7, arms the response |
// | parser, waits for its result and enforces the Ncc gap.  Rev 1.0       |
// +----------------------------------------------------------------------+
module sd_cmd_sender
  import sd_cmd_sender_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_STB,
  input  logic [5:0]  I_IDX,
  input  logic [31:0] I_ARG,
  input  logic [1:0]  I_RESP,
  output logic        O_READY,
  output logic        O_CMD_OUT,
  output logic        O_CMD_OE,
  output logic        O_RX_EN,
  output logic        O_RX_48,
  output logic        O_RX_136,
  input  logic        I_RX_TIC,
  input  logic        I_RX_CRC_OK,
  input  logic        I_RX_TIMEOUT,
  output logic        O_DONE,
  output logic        O_ST_OK,
  output logic        O_ST_CRCERR,
  output logic        O_ST_TIMEOUT
);

  localparam logic [5:0] c_LAST_BIT  = 6'(CMD_FRAME_BITS - 1);
  localparam logic [5:0] c_CRC_LAST  = 6'(CMD_CRC_BITS - 1);
  localparam logic [5:0] c_CRC_BITS  = 6'(CMD_CRC_BITS);
  localparam logic [3:0] c_TURN_LOAD = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] c_GAP_LOAD  = 4'(GAP_CYCLES - 1);

  sd_state_e   r_state;
  sd_state_e   w_next;
  logic [47:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic [3:0]  r_cnt;
  logic [1:0]  r_resp;
  logic        r_done;
  logic        r_st_ok;
  logic        r_st_crcerr;
  logic        r_st_timeout;
  logic [6:0]  w_crc;
  logic        w_crc_en;
  logic        w_crc_rst;
  logic        w_has_resp;
  logic        w_cnt_zero;
  logic        w_accept;

  assign w_has_resp = (r_resp == RESP_48) || (r_resp == RESP_136);
  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_crc_en   = (r_state == ST_SEND) && (r_bit_cnt < c_CRC_BITS);
  assign w_crc_rst  = RST || (r_state == ST_IDLE);

  sd_crc7 u_crc7 (
    .CLK   (CLK),
    .RST   (w_crc_rst),
    .EN    (w_crc_en),
    .SH    (1'b0),
    .I_DAT (r_shift[47]),
    .O_CRC (w_crc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    O_READY   = 1'b0;
    O_CMD_OE  = 1'b0;
    O_CMD_OUT = 1'b1;
    O_RX_EN   = 1'b0;
    O_RX_48   = 1'b0;
    O_RX_136  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        O_READY = 1'b1;
        if (I_STB) begin
          w_accept = 1'b1;
          w_next   = ST_SEND;
        end
      end
      ST_SEND: begin
        O_CMD_OE  = 1'b1;
        O_CMD_OUT = r_shift[47];
        if (r_bit_cnt == c_LAST_BIT) w_next = ST_TURN;
      end
      ST_TURN: begin
        if (w_cnt_zero) w_next = w_has_resp ? ST_WAIT : ST_GAP;
      end
      ST_WAIT: begin
        O_RX_EN  = 1'b1;
        O_RX_48  = (r_resp == RESP_48);
        O_RX_136 = (r_resp == RESP_136);
        if (I_RX_TIC || I_RX_TIMEOUT) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_cnt_zero) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift      <= 48'd0;
      r_bit_cnt    <= 6'd0;
      r_cnt        <= 4'd0;
      r_resp       <= RESP_NONE;
      r_done       <= 1'b0;
      r_st_ok      <= 1'b0;
      r_st_crcerr  <= 1'b0;
      r_st_timeout <= 1'b0;
    end else begin
      r_done <= (r_state == ST_GAP) && w_cnt_zero;

      // The trailing byte is overwritten by CRC7 and the end bit after bit 39.
      if (w_accept) begin
        r_shift      <= {2'b01, I_IDX, I_ARG, 8'h01};
        r_bit_cnt    <= 6'd0;
        r_resp       <= I_RESP;
        r_st_ok      <= 1'b0;
        r_st_crcerr  <= 1'b0;
        r_st_timeout <= 1'b0;
      end else if (r_state == ST_SEND) begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
        if (r_bit_cnt == c_CRC_LAST) begin
          r_shift <= {crc7_step(w_crc, r_shift[47]), 1'b1, 40'd0};
        end else begin
          r_shift <= {r_shift[46:0], 1'b0};
        end
      end

      if (w_next == ST_TURN && r_state != ST_TURN) begin
        r_cnt <= c_TURN_LOAD;
      end else if (w_next == ST_GAP && r_state != ST_GAP) begin
        r_cnt <= c_GAP_LOAD;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (r_state == ST_TURN && w_cnt_zero && !w_has_resp) begin
        r_st_ok <= 1'b1;
      end
      if (r_state == ST_WAIT) begin
        if (I_RX_TIC) begin
          r_st_ok     <= I_RX_CRC_OK;
          r_st_crcerr <= !I_RX_CRC_OK;
        end else if (I_RX_TIMEOUT) begin
          r_st_timeout <= 1'b1;
        end
      end
    end
  end

  assign O_DONE       = r_done;
  assign O_ST_OK      = r_st_ok;
  assign O_ST_CRCERR  = r_st_crcerr;
  assign O_ST_TIMEOUT = r_st_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_cmd_sender: directed, table-driven bench for sd_cmd_sender      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sd_cmd_sender;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_STB;
  logic [5:0]  I_IDX;
  logic [31:0] I_ARG;
  logic [1:0]  I_RESP;
  logic        O_READY, O_CMD_OUT, O_CMD_OE, O_RX_EN, O_RX_48, O_RX_136;
  logic        I_RX_TIC, I_RX_CRC_OK, I_RX_TIMEOUT;
  logic        O_DONE, O_ST_OK, O_ST_CRCERR, O_ST_TIMEOUT;

  int errors = 0;
  int checks = 0;

  sd_cmd_sender #(.TURN_CYCLES(2), .GAP_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .I_STB(I_STB), .I_IDX(I_IDX), .I_ARG(I_ARG), .I_RESP(I_RESP),
    .O_READY(O_READY), .O_CMD_OUT(O_CMD_OUT), .O_CMD_OE(O_CMD_OE), .O_RX_EN(O_RX_EN),
    .O_RX_48(O_RX_48), .O_RX_136(O_RX_136), .I_RX_TIC(I_RX_TIC), .I_RX_CRC_OK(I_RX_CRC_OK),
    .I_RX_TIMEOUT(I_RX_TIMEOUT), .O_DONE(O_DONE), .O_ST_OK(O_ST_OK),
    .O_ST_CRCERR(O_ST_CRCERR), .O_ST_TIMEOUT(O_ST_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // ev_kind: bit0 = parser tic, bit1 = timeout; st = {ok, crcerr, timeout}
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  resp;
    int          ev_tic;
    logic [1:0]  ev_kind;
    logic        crc_ok;
    int          stb_tic;
    logic [47:0] frame;
    int          done_tic;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for READY, requests the command; returns #1 after the accept edge (tic 1).
  task automatic start_cmd(input vec_t v);
    int w;
    w = 0;
    while (!O_READY && w < 100) begin
      @(posedge CLK); #1;
      w++;
    end
    chk("ready_before_stb", {63'd0, O_READY}, 64'd1);
    I_STB  = 1'b1;
    I_IDX  = v.idx;
    I_ARG  = v.arg;
    I_RESP = v.resp;
    @(posedge CLK); #1;
    I_STB  = 1'b0;
    I_IDX  = ~v.idx;
    I_ARG  = ~v.arg;
    I_RESP = ~v.resp;
  endtask

  // Follows a command from tic 1; returns at the negedge of the DONE tic.
  task automatic follow_cmd(input vec_t v);
    logic [47:0] frame;
    logic        oe_bad, rx_bad, sel_bad, rdy_bad, exp_rx, has_rsp;
    logic [2:0]  st_at_1;
    int          done_tic;
    int          t;
    frame = '0; oe_bad = 0; rx_bad = 0; sel_bad = 0; rdy_bad = 0; st_at_1 = '0;
    done_tic = -1;
    has_rsp = (v.resp == 2'b01) || (v.resp == 2'b10);
    t = 1;
    while (t <= 160 && done_tic < 0) begin
      I_RX_TIC     = (t == v.ev_tic) && v.ev_kind[0];
      I_RX_TIMEOUT = (t == v.ev_tic) && v.ev_kind[1];
      I_RX_CRC_OK  = v.crc_ok;
      I_STB        = (t == v.stb_tic);
      @(negedge CLK);
      if (t == 1) st_at_1 = {O_ST_OK, O_ST_CRCERR, O_ST_TIMEOUT};
      if (t <= 48) begin
        frame = {frame[46:0], O_CMD_OUT};
        if (O_CMD_OE !== 1'b1) oe_bad = 1;
      end else if (O_CMD_OE !== 1'b0 || O_CMD_OUT !== 1'b1) begin
        oe_bad = 1;
      end
      exp_rx = has_rsp && (t >= 51) && (t <= v.ev_tic);
      if (O_RX_EN !== exp_rx) rx_bad = 1;
      if (O_RX_48 !== (exp_rx && v.resp == 2'b01)) sel_bad = 1;
      if (O_RX_136 !== (exp_rx && v.resp == 2'b10)) sel_bad = 1;
      if (O_DONE === 1'b1) done_tic = t;
      else if (O_READY !== 1'b0) rdy_bad = 1;
      if (done_tic < 0) begin
        @(posedge CLK); #1;
        t++;
      end
    end
    I_RX_TIC = 0; I_RX_TIMEOUT = 0; I_STB = 0;
    chk("status_cleared", {61'd0, st_at_1}, 64'd0);
    chk("frame", {16'd0, frame}, {16'd0, v.frame});
    chk("cmd_oe_line", {63'd0, oe_bad}, 64'd0);
    chk("rx_en_window", {63'd0, rx_bad}, 64'd0);
    chk("rx_len_select", {63'd0, sel_bad}, 64'd0);
    chk("busy_not_ready", {63'd0, rdy_bad}, 64'd0);
    chk("done_tic", 64'(done_tic), 64'(v.done_tic));
    chk("status_at_done", {60'd0, O_READY, O_ST_OK, O_ST_CRCERR, O_ST_TIMEOUT},
        {60'd0, 1'b1, v.st});
  endtask

  initial begin
    logic done_seen, rdy_drop;
    vecs[0] = '{6'd0,  32'h0,     2'b00, 0,  2'b00, 1'b0, 0,  48'h400000000095, 59, 3'b100};
    vecs[1] = '{6'd8,  32'h1AA,   2'b01, 70, 2'b01, 1'b1, 10, 48'h48000001AA87, 79, 3'b100};
    vecs[2] = '{6'd2,  32'h0,     2'b10, 60, 2'b01, 1'b0, 0,  48'h42000000004D, 69, 3'b010};
    vecs[3] = '{6'd55, 32'h0,     2'b01, 80, 2'b10, 1'b1, 0,  48'h770000000065, 89, 3'b001};
    vecs[4] = '{6'd55, 32'h0,     2'b01, 55, 2'b11, 1'b1, 30, 48'h770000000065, 64, 3'b100};
    vecs[5] = '{6'd0,  32'h0,     2'b11, 0,  2'b00, 1'b0, 0,  48'h400000000095, 59, 3'b100};

    RST = 1; I_STB = 0; I_IDX = 0; I_ARG = 0; I_RESP = 0;
    I_RX_TIC = 0; I_RX_CRC_OK = 0; I_RX_TIMEOUT = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs",
        {54'd0, O_READY, O_CMD_OUT, O_CMD_OE, O_RX_EN, O_RX_48, O_RX_136,
         O_DONE, O_ST_OK, O_ST_CRCERR, O_ST_TIMEOUT},
        {54'd0, 10'b1100000000});
    @(posedge CLK); #1;
    RST = 0;

    // Consecutive vectors are requested in the DONE tic of the previous one.
    for (int i = 0; i < 6; i++) begin
      start_cmd(vecs[i]);
      follow_cmd(vecs[i]);
    end

    // Reset while frame bit 20 is on the line.
    start_cmd(vecs[1]);
    repeat (20) @(posedge CLK);
    #1;
    RST = 1;
    @(negedge CLK);
    chk("bit20_on_line", {62'd0, O_CMD_OE, O_CMD_OUT}, {62'd0, 1'b1, vecs[1].frame[27]});
    @(posedge CLK); #1;
    RST = 0;
    @(negedge CLK);
    chk("after_reset_line",
        {59'd0, O_READY, O_CMD_OUT, O_CMD_OE, O_RX_EN, O_DONE}, {59'd0, 5'b11000});
    done_seen = 0; rdy_drop = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge CLK);
      if (O_DONE !== 1'b0) done_seen = 1;
      if (O_READY !== 1'b1) rdy_drop = 1;
    end
    chk("no_done_after_reset", {62'd0, done_seen, rdy_drop}, 64'd0);
    start_cmd(vecs[0]);
    follow_cmd(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
